// File: rtl/rp_bfm_mmio_pkg.sv
// Shared types and constants for the root-port BFM MMIO sequencer.
// Covers TLP fmt/type codes, response status and sequencer state encodings.
package rp_bfm_mmio_pkg;

    localparam logic [7:0] MWR32 = 8'h40;
    localparam logic [7:0] MWR64 = 8'h60;
    localparam logic [7:0] MRD32 = 8'h00;
    localparam logic [7:0] MRD64 = 8'h20;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        ERR     = 2'd1,
        TIMEOUT = 2'd2
    } rsp_status_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_CPL = 2'd2,
        RESP     = 2'd3
    } state_e;

    // A 4-DW header is only needed when the address does not fit in 32 bits.
    function automatic logic [7:0] fmt_sel(input logic is_write, input logic hdr64);
        if (is_write) begin
            return hdr64 ? MWR64 : MWR32;
        end else begin
            return hdr64 ? MRD64 : MRD32;
        end
    endfunction

endpackage

// File: rtl/rp_bfm_timeout_ctr.sv
// Completion timeout counter: cleared on entry to the wait, counts while enabled,
// and flags expiry once it reaches TIMEOUT_CYCLES-1.
module rp_bfm_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_r;
    logic             expired_s;

    assign expired_s = (count_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign expired   = expired_s;

    // Wait-cycle counter; holds at the expiry value so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && !expired_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/rp_bfm_mmio_seq.sv
// Root-port BFM MMIO sequencer: turns one host command into an MWr/MRd request,
// then matches the read completion by tag (with timeout) and returns one response.
module rp_bfm_mmio_seq
    import rp_bfm_mmio_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_len64,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [63:0]       cmd_wdata,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_fmt_type,
    output logic [TAG_W-1:0]  tx_tag,
    output logic [9:0]        tx_len,
    output logic [ADDR_W-1:0] tx_addr,
    output logic [63:0]       tx_data,
    input  logic              cpl_valid,
    input  logic [TAG_W-1:0]  cpl_tag,
    input  logic [2:0]        cpl_status,
    input  logic [63:0]       cpl_data,
    output logic              rsp_valid,
    output logic [63:0]       rsp_data,
    output logic [1:0]        rsp_status,
    output logic [15:0]       stale_cnt
);

    state_e            state_r, next_state_s;
    logic              cmd_ready_r, tx_valid_r, rsp_valid_r;
    logic              cmd_write_r, cmd_len64_r;
    logic [7:0]        tx_fmt_type_r;
    logic [TAG_W-1:0]  tx_tag_r, tag_cnt_r;
    logic [9:0]        tx_len_r;
    logic [ADDR_W-1:0] tx_addr_r;
    logic [63:0]       tx_data_r, rsp_data_r;
    rsp_status_e       rsp_status_r;
    logic [15:0]       stale_cnt_r;
    logic              accept_s, tx_done_s, cpl_match_s, expired_s, wait_s;

    assign accept_s    = cmd_valid && cmd_ready_r;
    assign tx_done_s   = (state_r == SEND) && tx_ready;
    assign wait_s      = (state_r == WAIT_CPL);
    assign cpl_match_s = cpl_valid && wait_s && (cpl_tag == tx_tag_r);

    rp_bfm_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tx_done_s && !cmd_write_r),
        .enable  (wait_s),
        .expired (expired_s)
    );

    // Next-state logic; a matching completion and expiry both lead to RESP.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:     next_state_s = accept_s ? SEND : IDLE;
            SEND: begin
                if (tx_ready) begin
                    next_state_s = cmd_write_r ? IDLE : WAIT_CPL;
                end else begin
                    next_state_s = SEND;
                end
            end
            WAIT_CPL: next_state_s = (cpl_match_s || expired_s) ? RESP : WAIT_CPL;
            RESP:     next_state_s = IDLE;
            default:  next_state_s = IDLE;
        endcase
    end

    // State, handshake flags and the latched request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cmd_ready_r   <= 1'b0;
            tx_valid_r    <= 1'b0;
            cmd_write_r   <= 1'b0;
            cmd_len64_r   <= 1'b0;
            tx_fmt_type_r <= 8'h00;
            tx_tag_r      <= {TAG_W{1'b0}};
            tx_len_r      <= 10'd0;
            tx_addr_r     <= {ADDR_W{1'b0}};
            tx_data_r     <= 64'h0;
            tag_cnt_r     <= {TAG_W{1'b0}};
        end else begin
            state_r     <= next_state_s;
            cmd_ready_r <= (next_state_s == IDLE);
            tx_valid_r  <= (next_state_s == SEND);
            if (accept_s) begin
                cmd_write_r   <= cmd_write;
                cmd_len64_r   <= cmd_len64;
                tx_fmt_type_r <= fmt_sel(cmd_write, |cmd_addr[ADDR_W-1:32]);
                tx_tag_r      <= cmd_write ? {TAG_W{1'b0}} : tag_cnt_r;
                tx_len_r      <= cmd_len64 ? 10'd2 : 10'd1;
                tx_addr_r     <= cmd_addr;
                if (!cmd_write) begin
                    tx_data_r <= 64'h0;
                end else if (cmd_len64) begin
                    tx_data_r <= cmd_wdata;
                end else begin
                    tx_data_r <= {32'h0, cmd_wdata[31:0]};
                end
            end
            if (tx_done_s && !cmd_write_r) begin
                tag_cnt_r <= tag_cnt_r + {{(TAG_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Response capture (matching completion beats a same-cycle expiry) and stale counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= 64'h0;
            rsp_status_r <= OK;
            stale_cnt_r  <= 16'h0;
        end else begin
            rsp_valid_r <= (next_state_s == RESP);
            if (cpl_match_s) begin
                if (cpl_status == 3'd0) begin
                    rsp_status_r <= OK;
                    rsp_data_r   <= cmd_len64_r ? cpl_data : {32'h0, cpl_data[31:0]};
                end else begin
                    rsp_status_r <= ERR;
                    rsp_data_r   <= {64{1'b1}};
                end
            end else if (wait_s && expired_s) begin
                rsp_status_r <= TIMEOUT;
                rsp_data_r   <= {64{1'b1}};
            end
            if (cpl_valid && !cpl_match_s && (stale_cnt_r != 16'hFFFF)) begin
                stale_cnt_r <= stale_cnt_r + 16'd1;
            end
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign tx_valid    = tx_valid_r;
    assign tx_fmt_type = tx_fmt_type_r;
    assign tx_tag      = tx_tag_r;
    assign tx_len      = tx_len_r;
    assign tx_addr     = tx_addr_r;
    assign tx_data     = tx_data_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_status  = rsp_status_r;
    assign stale_cnt   = stale_cnt_r;

endmodule

// File: tb/tb_rp_bfm_mmio_seq.sv
// Directed bench for rp_bfm_mmio_seq with a short completion timeout (16 cycles).
module tb_rp_bfm_mmio_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_len64;
    logic [63:0] cmd_addr, cmd_wdata;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_fmt_type, tx_tag;
    logic [9:0]  tx_len;
    logic [63:0] tx_addr, tx_data;
    logic        cpl_valid;
    logic [7:0]  cpl_tag;
    logic [2:0]  cpl_status;
    logic [63:0] cpl_data;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_status;
    logic [15:0] stale_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_tag = 8'd0;

    always #5 clk = ~clk;

    rp_bfm_mmio_seq #(.ADDR_W(64), .TAG_W(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_len64(cmd_len64), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_fmt_type(tx_fmt_type),
        .tx_tag(tx_tag), .tx_len(tx_len), .tx_addr(tx_addr), .tx_data(tx_data),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_status(cpl_status),
        .cpl_data(cpl_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .stale_cnt(stale_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single edge; caller ensures cmd_ready is high.
    task automatic send_cmd(input logic wr, input logic l64, input logic [63:0] a,
                            input logic [63:0] d);
        cmd_valid = 1'b1; cmd_write = wr; cmd_len64 = l64; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_cpl(input logic [7:0] t, input logic [2:0] s, input logic [63:0] d);
        cpl_valid = 1'b1; cpl_tag = t; cpl_status = s; cpl_data = d;
        tick();
        cpl_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_len64 = 1'b0;
        cmd_addr = 64'h0; cmd_wdata = 64'h0; tx_ready = 1'b0;
        cpl_valid = 1'b0; cpl_tag = 8'h0; cpl_status = 3'd0; cpl_data = 64'h0;
        tick(); tick();
        checks++;
        if ({cmd_ready, tx_valid, rsp_valid} !== 3'b000 || stale_cnt !== 16'h0 ||
            tx_tag !== 8'h0 || rsp_data !== 64'h0 || rsp_status !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: cmd_ready=%b tx_valid=%b rsp_valid=%b stale=%h tag=%h rsp_data=%h, required all 0",
                     cmd_ready, tx_valid, rsp_valid, stale_cnt, tx_tag, rsp_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_mwr32();
        tx_ready = 1'b1;
        send_cmd(1'b1, 1'b0, 64'h1000, 64'h0000_0000_DEAD_BEEF);
        checks++;
        if (tx_valid !== 1'b1 || tx_fmt_type !== 8'h40 || tx_len !== 10'd1 ||
            tx_tag !== 8'h0 || tx_addr !== 64'h1000 || tx_data[31:0] !== 32'hDEADBEEF ||
            cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mwr32_fields: valid=%b fmt=%h len=%0d tag=%h addr=%h data=%h ready=%b, required 1/40/1/00/1000/DEADBEEF/0",
                     tx_valid, tx_fmt_type, tx_len, tx_tag, tx_addr, tx_data, cmd_ready);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL mwr32_ready_back: cmd_ready=%b tx_valid=%b required 1/0", cmd_ready, tx_valid);
        end
        tick(); tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mwr32_no_rsp: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_mrd64();
        tx_ready = 1'b1;
        send_cmd(1'b0, 1'b1, 64'h1_0000_0008, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++;
        if (tx_valid !== 1'b1 || tx_fmt_type !== 8'h20 || tx_len !== 10'd2 ||
            tx_tag !== exp_tag || tx_addr !== 64'h1_0000_0008 || tx_data !== 64'h0) begin
            errors++;
            $display("FAIL mrd64_fields: valid=%b fmt=%h len=%0d tag=%h addr=%h data=%h, required 1/20/2/%h/100000008/0",
                     tx_valid, tx_fmt_type, tx_len, tx_tag, tx_addr, tx_data, exp_tag);
        end
        tick();
        tick(); tick(); tick(); tick();
        send_cpl(exp_tag, 3'd0, 64'h0123_4567_89AB_CDEF);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'h0123_4567_89AB_CDEF || rsp_status !== 2'd0) begin
            errors++;
            $display("FAIL mrd64_rsp: valid=%b data=%h status=%0d, required 1/0123456789ABCDEF/0",
                     rsp_valid, rsp_data, rsp_status);
        end
        exp_tag = exp_tag + 8'd1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 64'h0123_4567_89AB_CDEF || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mrd64_pulse: valid=%b data=%h ready=%b, required 0/0123456789ABCDEF/1",
                     rsp_valid, rsp_data, cmd_ready);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        tx_ready = 1'b0;
        send_cmd(1'b0, 1'b0, 64'h2000, 64'h0);
        for (int i = 0; i < 10; i++) begin
            if (tx_valid !== 1'b1 || tx_tag !== exp_tag || tx_fmt_type !== 8'h00 ||
                tx_len !== 10'd1 || tx_addr !== 64'h2000 || tx_data !== 64'h0 || cmd_ready !== 1'b0)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stable: %0d unstable cycles, required 0 (tag=%h exp %h)", bad, tx_tag, exp_tag);
        end
        tx_ready = 1'b1;
        tick();
        checks++;
        if (tx_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_advance: tx_valid=%b rsp_valid=%b required 0/0", tx_valid, rsp_valid);
        end
        send_cpl(exp_tag, 3'd0, 64'hAAAA_BBBB_CCCC_DDDD);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'h0000_0000_CCCC_DDDD || rsp_status !== 2'd0) begin
            errors++;
            $display("FAIL bp_rsp_1dw: valid=%b data=%h status=%0d, required 1/00000000CCCCDDDD/0",
                     rsp_valid, rsp_data, rsp_status);
        end
        exp_tag = exp_tag + 8'd1;
        tick();
    endtask

    task automatic test_timeout();
        int early = 0;
        tx_ready = 1'b1;
        send_cmd(1'b0, 1'b1, 64'h3000, 64'h0);
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
            if (rsp_valid !== 1'b0) early++;
        end
        tick();
        checks++;
        if (early != 0 || rsp_valid !== 1'b1 || rsp_status !== 2'd2 || rsp_data !== {64{1'b1}}) begin
            errors++;
            $display("FAIL timeout_rsp: early=%0d valid=%b status=%0d data=%h, required 0/1/2/all-ones",
                     early, rsp_valid, rsp_status, rsp_data);
        end
        exp_tag = exp_tag + 8'd1;
        tick();
        send_cmd(1'b0, 1'b1, 64'h3008, 64'h0);
        tick();
        for (int i = 1; i < 16; i++) tick();
        send_cpl(exp_tag, 3'd0, 64'h5555_6666_7777_8888);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 || rsp_data !== 64'h5555_6666_7777_8888) begin
            errors++;
            $display("FAIL timeout_race: valid=%b status=%0d data=%h, required 1/0/5555666677778888",
                     rsp_valid, rsp_status, rsp_data);
        end
        exp_tag = exp_tag + 8'd1;
        tick();
    endtask

    task automatic test_err_stale();
        tx_ready = 1'b1;
        send_cmd(1'b0, 1'b0, 64'h4000, 64'h0);
        tick();
        send_cpl(exp_tag + 8'd5, 3'd0, 64'h1234);
        checks++;
        if (rsp_valid !== 1'b0 || stale_cnt !== 16'd1) begin
            errors++;
            $display("FAIL stale_mismatch: rsp_valid=%b stale=%0d, required 0/1", rsp_valid, stale_cnt);
        end
        send_cpl(exp_tag, 3'd4, 64'h1234);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'd1 || rsp_data !== {64{1'b1}} || stale_cnt !== 16'd1) begin
            errors++;
            $display("FAIL err_rsp: valid=%b status=%0d data=%h stale=%0d, required 1/1/all-ones/1",
                     rsp_valid, rsp_status, rsp_data, stale_cnt);
        end
        exp_tag = exp_tag + 8'd1;
        tick();
    endtask

    task automatic test_tag_wrap();
        int bad = 0;
        int wraps = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_cmd(1'b0, 1'b0, 64'h5000, 64'h0);
            if (tx_tag !== exp_tag) bad++;
            tick();
            send_cpl(exp_tag, 3'd0, 64'h0);
            if (rsp_valid !== 1'b1 || rsp_status !== 2'd0) bad++;
            if (exp_tag == 8'd255) wraps++;
            exp_tag = exp_tag + 8'd1;
            tick();
        end
        send_cmd(1'b0, 1'b0, 64'h5000, 64'h0);
        checks++;
        if (bad != 0 || wraps != 1 || tx_tag !== exp_tag) begin
            errors++;
            $display("FAIL tag_wrap: bad=%0d wraps=%0d tag=%h, required 0/1/%h", bad, wraps, tx_tag, exp_tag);
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_cpl(exp_tag, 3'd0, 64'h9999);
        checks++;
        if (rsp_valid !== 1'b0 || stale_cnt !== 16'd1 || cmd_ready !== 1'b1 || tx_tag !== 8'h0) begin
            errors++;
            $display("FAIL reset_inflight: rsp_valid=%b stale=%0d ready=%b tag=%h, required 0/1/1/00",
                     rsp_valid, stale_cnt, cmd_ready, tx_tag);
        end
        tick();
        send_cmd(1'b0, 1'b0, 64'h6000, 64'h0);
        checks++;
        if (tx_valid !== 1'b1 || tx_tag !== 8'h0) begin
            errors++;
            $display("FAIL reset_tag: tx_valid=%b tag=%h, required 1/00", tx_valid, tx_tag);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mwr32();
        test_mrd64();
        test_backpressure();
        test_timeout();
        test_err_stale();
        test_tag_wrap();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
